// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Holds the scan FSM state type, the digit code width and the blanking code.
package display_pkg;

    localparam int DIGIT_W = 4;

    // Code 4'hF is the encoder's default input and produces a dark digit
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SETTLE,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter that times how long one digit's anode stays lit.
// The zero flag marks the last cycle of the dwell window.
module scan_dwell_counter #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_value,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [DWELL_W-1:0] r_count;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment encoder.
// Each digit goes through PRESENT (code + ready strobe), SETTLE (anodes dark)
// and SHOW (anode lit for DWELL_CYCLES). New values arrive through a shadow
// register and are only moved to the display register at a frame start, so
// a frame never mixes old and new digits.
// Optional build macro DISPLAY_SCAN_LEADING_ZERO_BLANK_EN: blank leading zeros
// (every digit above digit 0) when the display register is refreshed.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
    output logic                          load_ack,
    output logic                          busy,
    output logic [DIGIT_W-1:0]            code,
    output logic                          ready,
    output logic [NUM_DIGITS-1:0]         digit_en_n
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    // Blanks every zero digit that has only zeros above it; digit 0 always shows
    function automatic digits_t blankLeadingZeros(input digits_t value);
        digits_t result;
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        logic allZero;
        result  = value;
        allZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (value[i] != '0) begin
                allZero = 1'b0;
            end
            if (allZero) begin
                result[i] = BLANK_CODE;
            end
        end
`else
        result = value;
`endif
        return result;
    endfunction

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_idx;
    digits_t               r_display;
    digits_t               r_shadow;
    logic                  r_busy;
    logic                  r_load_ack;
    logic [DIGIT_W-1:0]    r_code;
    logic                  r_ready;
    logic [NUM_DIGITS-1:0] r_digit_en_n;

    logic                  w_dwell_zero;
    logic                  w_boundary;
    logic                  w_frame_start;
    logic                  w_copy;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_next_idx;
    digits_t               w_next_display;

    // A frame starts when leaving IDLE or when the last digit's dwell ends with enable still high
    assign w_boundary     = (r_state == SHOW) && w_dwell_zero;
    assign w_frame_start  = ((r_state == IDLE) && enable) ||
                            (w_boundary && enable && (r_idx == LAST_IDX));
    assign w_copy         = w_frame_start && r_busy;
    assign w_accept       = load && !r_busy;
    assign w_next_display = w_copy ? blankLeadingZeros(r_shadow) : r_display;
    assign w_next_idx     = ((r_state == IDLE) || (r_idx == LAST_IDX)) ? '0 : r_idx + 1'b1;

    scan_dwell_counter #(
        .DWELL_W(DWELL_W)
    ) u_dwell (
        .clk         (clk),
        .reset       (reset),
        .i_load      (r_state == SETTLE),
        .i_load_value(DWELL_RELOAD),
        .i_dec       (r_state == SHOW),
        .o_zero      (w_dwell_zero)
    );

    // Scan FSM: sequences each digit and drives the registered encoder/anode outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_display    <= {NUM_DIGITS{BLANK_CODE}};
            r_code       <= BLANK_CODE;
            r_ready      <= 1'b0;
            r_digit_en_n <= '1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready      <= 1'b0;
                    r_digit_en_n <= '1;
                    if (enable) begin
                        r_state   <= PRESENT;
                        r_idx     <= w_next_idx;
                        r_display <= w_next_display;
                        r_code    <= w_next_display[w_next_idx];
                        r_ready   <= 1'b1;
                    end
                end
                PRESENT: begin
                    r_ready <= 1'b0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_digit_en_n <= ~(NUM_DIGITS'(1) << r_idx);
                    r_state      <= SHOW;
                end
                SHOW: begin
                    if (w_dwell_zero) begin
                        r_digit_en_n <= '1;
                        if (!enable) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= PRESENT;
                            r_idx     <= w_next_idx;
                            r_display <= w_next_display;
                            r_code    <= w_next_display[w_next_idx];
                            r_ready   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Load handshake: accept into the shadow when idle, release busy once the frame copy happens
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= {NUM_DIGITS{BLANK_CODE}};
            r_busy     <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= w_accept;
            if (w_accept) begin
                r_shadow <= bcd_in;
                r_busy   <= 1'b1;
            end else if (w_copy) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign load_ack   = r_load_ack;
    assign busy       = r_busy;
    assign code       = r_code;
    assign ready      = r_ready;
    assign digit_en_n = r_digit_en_n;

endmodule
